// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: data word, FSM state encoding and a width helper.
package mem_arbiter_pkg;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus of the arbiter, bundled for port hookup.
interface mem_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  import mem_arbiter_pkg::*;

  logic  [NREQ-1:0] req;
  logic  [NREQ-1:0] req_we;
  word_t [NREQ-1:0] req_addr;
  word_t [NREQ-1:0] req_wdata;
  word_t            req_rdata;
  logic  [NREQ-1:0] req_ready;
  word_t            mem_addr;
  word_t            mem_din;
  logic             mem_write_en;
  word_t            mem_dout;
  logic             busy;

  // Arbiter side
  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_dout,
    output req_rdata, req_ready, mem_addr, mem_din, mem_write_en, busy
  );

  // Requesters plus memory, as seen from outside the arbiter
  modport master (
    output req, req_we, req_addr, req_wdata, mem_dout,
    input  req_rdata, req_ready, mem_addr, mem_din, mem_write_en, busy
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin selector: first set req bit scanning from last+1, wrapping.
module rr_picker
  import mem_arbiter_pkg::*;
#(
  parameter  int unsigned NREQ  = 2,
  localparam int unsigned IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] cand;

  // last + i never exceeds 2*NREQ-1, so one conditional subtract is a full modulo
  always_comb begin
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last} + SUM_W'(i);
      if (cand >= SUM_W'(NREQ)) cand = cand - SUM_W'(NREQ);
      if (!valid && req[cand[IDX_W-1:0]]) begin
        grant = cand[IDX_W-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving NREQ requesters single-access turns on one fixed-latency memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = idx_width(NREQ);
  localparam int unsigned CNT_W = idx_width(MEM_LAT);

  arb_state_t       state, state_n;
  logic [CNT_W-1:0] wait_cnt, wait_n;
  logic [IDX_W-1:0] g, g_n;
  logic [IDX_W-1:0] last, last_n;
  word_t            rdata_q, rdata_n;
  word_t            addr_q, addr_n;
  word_t            din_q, din_n;
  logic             we_q, we_n;
  logic [NREQ-1:0]  ready_q, ready_n;
  logic             busy_q, busy_n;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;

  rr_picker #(.NREQ(NREQ)) u_rr_picker (
    .req   (bus.req),
    .last  (last),
    .grant (pick_idx),
    .valid (pick_vld)
  );

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      g        <= '0;
      last     <= IDX_W'(NREQ - 1);
      rdata_q  <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
      ready_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      g        <= g_n;
      last     <= last_n;
      rdata_q  <= rdata_n;
      addr_q   <= addr_n;
      din_q    <= din_n;
      we_q     <= we_n;
      ready_q  <= ready_n;
      busy_q   <= busy_n;
    end
  end

  // Next state; output values are prepared one cycle ahead so they land with the state
  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    g_n     = g;
    last_n  = last;
    rdata_n = rdata_q;
    addr_n  = '0;
    din_n   = '0;
    we_n    = 1'b0;
    ready_n = '0;

    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_n = ACCESS;
          g_n     = pick_idx;
          wait_n  = '0;
          addr_n  = bus.req_addr[pick_idx];
          din_n   = bus.req_wdata[pick_idx];
          we_n    = bus.req_we[pick_idx];
        end
      end

      ACCESS: begin
        if (wait_cnt == CNT_W'(MEM_LAT - 1)) begin
          state_n    = RESP;
          rdata_n    = bus.mem_dout;
          ready_n[g] = 1'b1;
        end else begin
          wait_n = wait_cnt + CNT_W'(1);
          addr_n = addr_q;
          din_n  = din_q;
        end
      end

      RESP: begin
        state_n = IDLE;
        last_n  = g;
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  assign bus.req_rdata    = rdata_q;
  assign bus.req_ready    = ready_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_din      = din_q;
  assign bus.mem_write_en = we_q;
  assign bus.busy         = busy_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NREQ, default 2: number of requesters; range 2..4.
REQ-002 Parameter MEM_LAT, default 1: memory read latency in cycles; range 1..4.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req  input  NREQ  per-requester access request; held high until the matching req_ready.
REQ-006 req_we  input  NREQ  per-requester write enable; 1 = write, 0 = read.
REQ-007 req_addr  input  NREQ x word_t  per-requester address.
REQ-008 req_wdata  input  NREQ x word_t  per-requester write data.
REQ-009 req_rdata  output  word_t  read data, shared by all requesters; valid only while req_ready[g] is high for the granted requester g.
REQ-010 req_ready  output  NREQ  one-cycle completion pulse, one-hot or zero.
REQ-011 mem_addr  output  word_t  memory address.
REQ-012 mem_din  output  word_t  memory write data.
REQ-013 mem_write_en  output  1  memory write strobe.
REQ-014 mem_dout  input  word_t  memory read data; valid MEM_LAT cycles after the address is presented.
REQ-015 busy  output  1  high while the state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-017 In IDLE with any req bit set, the block SHALL latch grant index g at the clock edge, pick g by round-robin starting at last+1 (mod NREQ), and enter ACCESS.
REQ-018 In IDLE with no req bit set, the block SHALL stay in IDLE.
REQ-019 ACCESS SHALL last exactly MEM_LAT cycles, counted by a wait counter cleared on entry.
REQ-020 During ACCESS, mem_addr and mem_din SHALL equal req_addr[g] and req_wdata[g].
REQ-021 mem_write_en SHALL equal req_we[g] in the first ACCESS cycle only, and SHALL be 0 otherwise, so each write occurs exactly once.
REQ-022 At the edge ending the last ACCESS cycle, the block SHALL capture mem_dout into the rdata register and enter RESP.
REQ-023 In RESP, req_ready[g] SHALL be 1 and req_rdata SHALL be the captured value; on writes, req_rdata is don't-care.
REQ-024 On leaving RESP, last SHALL be set to g and the state SHALL return to IDLE.
REQ-025 A new grant SHALL be possible in the cycle after RESP, giving one access per MEM_LAT+2 cycles.
REQ-026 Request-to-ready latency SHALL be MEM_LAT+1 cycles: req sampled at edge N gives req_ready high in cycle N+MEM_LAT+1.
REQ-027 Simultaneous requests SHALL be served in round-robin order; no requester waits more than NREQ-1 grants.
REQ-028 If req[g] drops during ACCESS, the access SHALL still complete; the req_ready pulse is still issued and ignored.
REQ-029 Requests arriving during ACCESS or RESP SHALL wait for the next IDLE.
REQ-030 The last pointer SHALL wrap from NREQ-1 to 0.
REQ-031 When not in ACCESS, mem_addr and mem_din SHALL be 0.

Reset
REQ-032 While rst is high, the state SHALL be IDLE, last SHALL be NREQ-1 (so requester 0 wins first), and the wait counter, g and the rdata register SHALL be 0.
REQ-033 While rst is high, req_ready, mem_write_en, busy, mem_addr and mem_din SHALL all be 0.
REQ-034 Reset asserted mid-access SHALL abort the access with no req_ready pulse; a write already strobed is not undone.

Structure
REQ-035 arb_state_t (IDLE/ACCESS/RESP) SHALL be defined in the shared types package next to word_t.
REQ-036 Round-robin selection SHALL be a combinational sub-module rr_picker with inputs req and last, and outputs grant index and grant valid.

Verification
REQ-037 Single read, MEM_LAT=1: req[0]=1, we=0, addr=0x10, memory returns 0xCAFE -> mem_addr=0x10 for 1 cycle, req_ready[0] high 2 cycles after the sample edge, req_rdata=0xCAFE.
REQ-038 Single write: req[1]=1, we=1, addr=0x20, wdata=0x55 -> mem_write_en high exactly 1 cycle with mem_addr=0x20 and mem_din=0x55, then a req_ready[1] pulse.
REQ-039 Contention after reset: req=2'b11 held continuously -> grants 0,1,0,1, with req_ready pulses 3 cycles apart.
REQ-040 MEM_LAT=3: read of addr 0x8 -> ACCESS lasts 3 cycles, mem_write_en stays 0, req_ready 4 cycles after the sample edge.
REQ-041 Reset in the second ACCESS cycle (MEM_LAT=3) -> no req_ready pulse, busy=0 immediately, and the next request is granted to requester 0.
REQ-042 Requester withdrawal: req[0] drops during ACCESS -> the access completes, the req_ready[0] pulse is issued, and a pending req[1] is granted next.
